// File: rtl/capture_addr_gen.sv
// Triggered write-address generator for the acquisition RAM.
// Sequences arm -> pre-trigger fill -> trigger wait -> post-trigger fill -> done.
module capture_addr_gen #(
   parameter int FRAME_LEN = 200,
   parameter int ADDR_W    = 9
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              sample_en,
   input  logic              sample_type,
   input  logic [ADDR_W-1:0] pretrig,
   input  logic              arm,
   input  logic              trigger,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [ADDR_W-1:0] trig_addr,
   output logic [ADDR_W-1:0] start_addr,
   output logic              busy,
   output logic              done
);

   localparam int CW = ADDR_W + 1;
   localparam logic [CW-1:0] LEN_S = CW'(FRAME_LEN);
   localparam logic [CW-1:0] LEN_D = CW'(2 * FRAME_LEN);
   localparam logic [CW-1:0] ONE   = CW'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRE,
      S_WAIT_TRIG,
      S_POST,
      S_DONE
   } state_t;

   state_t            state_reg, state_next;
   logic              type_l_reg, type_l_next;
   logic [ADDR_W-1:0] pre_l_reg, pre_l_next;
   logic [ADDR_W-1:0] pre_cnt_reg, pre_cnt_next;
   logic [CW-1:0]     post_cnt_reg, post_cnt_next;
   logic [ADDR_W-1:0] ram_addr_reg, ram_addr_next;
   logic [ADDR_W-1:0] trig_addr_reg, trig_addr_next;
   logic [ADDR_W-1:0] start_addr_reg, start_addr_next;

   logic [CW-1:0]     len_l;
   logic [CW-1:0]     len_arm_m1;
   logic [ADDR_W-1:0] pre_clamp;
   logic [ADDR_W-1:0] addr_inc;
   logic [ADDR_W-1:0] pre_cnt_inc;
   logic [CW-1:0]     post_full;
   logic [ADDR_W-1:0] start_base;
   logic [ADDR_W-1:0] start_calc;
   logic              capturing;

   assign capturing = (state_reg == S_PRE) || (state_reg == S_WAIT_TRIG) ||
                      (state_reg == S_POST);

   assign len_l      = type_l_reg ? LEN_D : LEN_S;
   assign len_arm_m1 = (sample_type ? LEN_D : LEN_S) - ONE;
   assign pre_clamp  = ({1'b0, pretrig} > len_arm_m1) ? len_arm_m1[ADDR_W-1:0] : pretrig;

   assign addr_inc    = ({1'b0, ram_addr_reg} == (len_l - ONE)) ? '0 : ram_addr_reg + 1'b1;
   assign pre_cnt_inc = pre_cnt_reg + 1'b1;
   assign post_full   = len_l - {1'b0, pre_l_reg};

   // The result is always below len, so modular ADDR_W-bit math with a len
   // correction on underflow gives the exact record start.
   assign start_base = (state_reg == S_WAIT_TRIG) ? ram_addr_reg : trig_addr_reg;
   assign start_calc = (start_base < pre_l_reg) ?
                       start_base - pre_l_reg + len_l[ADDR_W-1:0] :
                       start_base - pre_l_reg;

   always_comb begin
      state_next      = state_reg;
      type_l_next     = type_l_reg;
      pre_l_next      = pre_l_reg;
      pre_cnt_next    = pre_cnt_reg;
      post_cnt_next   = post_cnt_reg;
      ram_addr_next   = ram_addr_reg;
      trig_addr_next  = trig_addr_reg;
      start_addr_next = start_addr_reg;

      if (arm) begin
         // arm wins over everything, including a coincident trigger
         type_l_next   = sample_type;
         pre_l_next    = pre_clamp;
         ram_addr_next = '0;
         pre_cnt_next  = '0;
         state_next    = (pre_clamp != '0) ? S_PRE : S_WAIT_TRIG;
      end else begin
         if (ram_we) begin
            ram_addr_next = addr_inc;
         end
         case (state_reg)
            S_PRE: begin
               if (sample_en) begin
                  pre_cnt_next = pre_cnt_inc;
                  if (pre_cnt_inc == pre_l_reg) begin
                     state_next = S_WAIT_TRIG;
                  end
               end
            end
            S_WAIT_TRIG: begin
               if (trigger) begin
                  trig_addr_next = ram_addr_reg;
                  if (sample_en) begin
                     post_cnt_next = post_full - ONE;
                     if (post_full == ONE) begin
                        state_next      = S_DONE;
                        start_addr_next = start_calc;
                     end else begin
                        state_next = S_POST;
                     end
                  end else begin
                     post_cnt_next = post_full;
                     state_next    = S_POST;
                  end
               end
            end
            S_POST: begin
               if (sample_en) begin
                  post_cnt_next = post_cnt_reg - ONE;
                  if (post_cnt_reg == ONE) begin
                     state_next      = S_DONE;
                     start_addr_next = start_calc;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg      <= S_IDLE;
         type_l_reg     <= 1'b0;
         pre_l_reg      <= '0;
         pre_cnt_reg    <= '0;
         post_cnt_reg   <= '0;
         ram_addr_reg   <= '0;
         trig_addr_reg  <= '0;
         start_addr_reg <= '0;
      end else begin
         state_reg      <= state_next;
         type_l_reg     <= type_l_next;
         pre_l_reg      <= pre_l_next;
         pre_cnt_reg    <= pre_cnt_next;
         post_cnt_reg   <= post_cnt_next;
         ram_addr_reg   <= ram_addr_next;
         trig_addr_reg  <= trig_addr_next;
         start_addr_reg <= start_addr_next;
      end
   end

   assign ram_we     = sample_en && capturing;
   assign ram_addr   = ram_addr_reg;
   assign trig_addr  = trig_addr_reg;
   assign start_addr = start_addr_reg;
   assign busy       = capturing;
   assign done       = (state_reg == S_DONE);

endmodule
